controlador_de_disparos: RTL and testbench



---
 rtl/controlador_de_disparos.sv | 179 +++++++++++++++++
 tb/tb_controlador_de_disparos.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_de_disparos.sv
// Shot controller for the naval-battle game: latches the ship map, counts targets, then scores shots.
// Optional macro DISPARO_REPETIDO_EN: repeated shots pulse repetido and do not consume the budget.
module controlador_de_disparos #(
    parameter int COLS      = 5,
    parameter int ROWS      = 7,
    parameter int MAX_SHOTS = 20,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int N  = COLS * ROWS,
    localparam int NW = $clog2(N + 1),
    localparam int SW = $clog2(MAX_SHOTS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          confirmar,
    input  logic [CW-1:0] coordColuna,
    input  logic [RW-1:0] coordLinha,
    input  logic [N-1:0]  mapa,
    output logic [N-1:0]  matriz,
    output logic [N-1:0]  disparos,
    output logic [NW-1:0] acertos,
    output logic [SW-1:0] restantes,
    output logic          acerto,
    output logic          erro,
    output logic          repetido,
    output logic          invalido,
    output logic          pronto,
    output logic          fim_de_jogo,
    output logic          vitoria
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  mapa_reg, mapa_next;
    logic [N-1:0]  matriz_reg, matriz_next;
    logic [N-1:0]  disparos_reg, disparos_next;
    logic [NW-1:0] acertos_reg, acertos_next;
    logic [NW-1:0] alvos_reg, alvos_next;
    logic [SW-1:0] restantes_reg, restantes_next;
    logic [IW-1:0] scan_reg, scan_next;
    logic          acerto_reg, acerto_next;
    logic          erro_reg, erro_next;
    logic          repetido_reg, repetido_next;
    logic          invalido_reg, invalido_next;
    logic          confirmar_q_reg;
    logic          shot;
    logic          coord_ok;
    logic [IW-1:0] cell_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            mapa_reg        <= '0;
            matriz_reg      <= '0;
            disparos_reg    <= '0;
            acertos_reg     <= '0;
            alvos_reg       <= '0;
            restantes_reg   <= '0;
            scan_reg        <= '0;
            acerto_reg      <= 1'b0;
            erro_reg        <= 1'b0;
            repetido_reg    <= 1'b0;
            invalido_reg    <= 1'b0;
            confirmar_q_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mapa_reg        <= mapa_next;
            matriz_reg      <= matriz_next;
            disparos_reg    <= disparos_next;
            acertos_reg     <= acertos_next;
            alvos_reg       <= alvos_next;
            restantes_reg   <= restantes_next;
            scan_reg        <= scan_next;
            acerto_reg      <= acerto_next;
            erro_reg        <= erro_next;
            repetido_reg    <= repetido_next;
            invalido_reg    <= invalido_next;
            confirmar_q_reg <= confirmar;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mapa_next      = mapa_reg;
        matriz_next    = matriz_reg;
        disparos_next  = disparos_reg;
        acertos_next   = acertos_reg;
        alvos_next     = alvos_reg;
        restantes_next = restantes_reg;
        scan_next      = scan_reg;
        acerto_next    = 1'b0;
        erro_next      = 1'b0;
        repetido_next  = 1'b0;
        invalido_next  = 1'b0;
        shot           = confirmar & ~confirmar_q_reg;
        coord_ok       = (int'(coordColuna) < COLS) && (int'(coordLinha) < ROWS);
        cell_idx       = IW'(int'(coordColuna) * ROWS + int'(coordLinha));

        // enable low overrides everything, including a shot edge sampled on the same clock
        if (!enable) begin
            state_next     = IDLE;
            matriz_next    = '0;
            disparos_next  = '0;
            acertos_next   = '0;
            alvos_next     = '0;
            restantes_next = '0;
            scan_next      = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next     = LOAD;
                    mapa_next      = mapa;
                    matriz_next    = '0;
                    disparos_next  = '0;
                    acertos_next   = '0;
                    alvos_next     = '0;
                    restantes_next = SW'(MAX_SHOTS);
                    scan_next      = '0;
                end
                LOAD: begin
                    alvos_next = alvos_reg + NW'(mapa_reg[scan_reg]);
                    scan_next  = scan_reg + IW'(1);
                    if (scan_reg == IW'(N - 1)) begin
                        state_next = (alvos_next == '0) ? WIN : PLAY;
                    end
                end
                PLAY: begin
                    if (shot) begin
                        if (!coord_ok) begin
                            invalido_next = 1'b1;
                        end else if (disparos_reg[cell_idx]) begin
`ifdef DISPARO_REPETIDO_EN
                            repetido_next = 1'b1;
`else
                            erro_next      = 1'b1;
                            restantes_next = restantes_reg - SW'(1);
`endif
                        end else begin
                            disparos_next[cell_idx] = 1'b1;
                            matriz_next[cell_idx]   = mapa_reg[cell_idx];
                            restantes_next          = restantes_reg - SW'(1);
                            if (mapa_reg[cell_idx]) begin
                                acertos_next = acertos_reg + NW'(1);
                                acerto_next  = 1'b1;
                            end else begin
                                erro_next = 1'b1;
                            end
                        end
                        // win is tested first so a final hit on the last shot counts as victory
                        if (acertos_next == alvos_reg) begin
                            state_next = WIN;
                        end else if (restantes_next == '0) begin
                            state_next = LOSE;
                        end
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    assign matriz      = matriz_reg;
    assign disparos    = disparos_reg;
    assign acertos     = acertos_reg;
    assign restantes   = restantes_reg;
    assign acerto      = acerto_reg;
    assign erro        = erro_reg;
    assign repetido    = repetido_reg;
    assign invalido    = invalido_reg;
    assign pronto      = (state_reg == PLAY);
    assign fim_de_jogo = (state_reg == WIN) || (state_reg == LOSE);
    assign vitoria     = (state_reg == WIN);

endmodule

// File: tb/tb_controlador_de_disparos.sv
// Bench for controlador_de_disparos: three instances (budgets 20, 8, 3) share one stimulus stream
// and are scored against a game-level model of the rules.
module tb_controlador_de_disparos;
    localparam int COLS = 5;
    localparam int ROWS = 7;
    localparam int N    = COLS * ROWS;
    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_PLAY = 2, ST_WIN = 3, ST_LOSE = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         confirmar = 1'b0;
    logic [2:0]   coordColuna = '0;
    logic [2:0]   coordLinha = '0;
    logic [N-1:0] mapa = '0;

    logic [N-1:0] matriz_o [3];
    logic [N-1:0] disparos_o [3];
    logic [5:0]   acertos_o [3];
    logic [4:0]   rest0;
    logic [3:0]   rest1;
    logic [1:0]   rest2;
    logic [2:0]   acerto_o, erro_o, repetido_o, invalido_o, pronto_o, fim_o, vitoria_o;

    always #5 clk = ~clk;

    controlador_de_disparos #(.COLS(COLS), .ROWS(ROWS), .MAX_SHOTS(20)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .confirmar(confirmar),
        .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
        .matriz(matriz_o[0]), .disparos(disparos_o[0]), .acertos(acertos_o[0]), .restantes(rest0),
        .acerto(acerto_o[0]), .erro(erro_o[0]), .repetido(repetido_o[0]), .invalido(invalido_o[0]),
        .pronto(pronto_o[0]), .fim_de_jogo(fim_o[0]), .vitoria(vitoria_o[0]));

    controlador_de_disparos #(.COLS(COLS), .ROWS(ROWS), .MAX_SHOTS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .confirmar(confirmar),
        .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
        .matriz(matriz_o[1]), .disparos(disparos_o[1]), .acertos(acertos_o[1]), .restantes(rest1),
        .acerto(acerto_o[1]), .erro(erro_o[1]), .repetido(repetido_o[1]), .invalido(invalido_o[1]),
        .pronto(pronto_o[1]), .fim_de_jogo(fim_o[1]), .vitoria(vitoria_o[1]));

    controlador_de_disparos #(.COLS(COLS), .ROWS(ROWS), .MAX_SHOTS(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .confirmar(confirmar),
        .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
        .matriz(matriz_o[2]), .disparos(disparos_o[2]), .acertos(acertos_o[2]), .restantes(rest2),
        .acerto(acerto_o[2]), .erro(erro_o[2]), .repetido(repetido_o[2]), .invalido(invalido_o[2]),
        .pronto(pronto_o[2]), .fim_de_jogo(fim_o[2]), .vitoria(vitoria_o[2]));

    int           tests = 0;
    int           fails = 0;
    int           budget [3] = '{20, 8, 3};
    int           st [3];
    int           hits [3];
    int           rem [3];
    logic [N-1:0] shot_m [3];
    logic [N-1:0] rev_m [3];
    logic         ex_ac [3], ex_er [3], ex_rp [3], ex_iv [3];
    logic [N-1:0] map_m;
    int           targets;
    logic [N-1:0] ships;

    function automatic logic [7:0] rest_of(input int k);
        case (k)
            0:       return 8'(rest0);
            1:       return 8'(rest1);
            default: return 8'(rest2);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s [inst%0d] observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, " matriz"},    k, 64'(matriz_o[k]),   64'(rev_m[k]));
            chk({tag, " disparos"},  k, 64'(disparos_o[k]), 64'(shot_m[k]));
            chk({tag, " acertos"},   k, 64'(acertos_o[k]),  64'(hits[k]));
            chk({tag, " restantes"}, k, 64'(rest_of(k)),    64'(rem[k]));
            chk({tag, " acerto"},    k, 64'(acerto_o[k]),   64'(ex_ac[k]));
            chk({tag, " erro"},      k, 64'(erro_o[k]),     64'(ex_er[k]));
            chk({tag, " repetido"},  k, 64'(repetido_o[k]), 64'(ex_rp[k]));
            chk({tag, " invalido"},  k, 64'(invalido_o[k]), 64'(ex_iv[k]));
            chk({tag, " pronto"},    k, 64'(pronto_o[k]),   64'(st[k] == ST_PLAY));
            chk({tag, " fim"},       k, 64'(fim_o[k]),      64'(st[k] == ST_WIN || st[k] == ST_LOSE));
            chk({tag, " vitoria"},   k, 64'(vitoria_o[k]),  64'(st[k] == ST_WIN));
        end
    endtask

    task automatic clear_pulses();
        for (int k = 0; k < 3; k++) begin
            ex_ac[k] = 1'b0; ex_er[k] = 1'b0; ex_rp[k] = 1'b0; ex_iv[k] = 1'b0;
        end
    endtask

    task automatic model_idle();
        clear_pulses();
        for (int k = 0; k < 3; k++) begin
            st[k] = ST_IDLE; hits[k] = 0; rem[k] = 0; shot_m[k] = '0; rev_m[k] = '0;
        end
    endtask

    // One accepted fire edge applied to each game according to the rules of play
    task automatic model_shot(input int c, input int r);
        int i;
        clear_pulses();
        for (int k = 0; k < 3; k++) begin
            if (st[k] != ST_PLAY) continue;
            if (c >= COLS || r >= ROWS) begin
                ex_iv[k] = 1'b1;
                continue;
            end
            i = c * ROWS + r;
            if (shot_m[k][i]) begin
`ifdef DISPARO_REPETIDO_EN
                ex_rp[k] = 1'b1;
                continue;
`else
                ex_er[k] = 1'b1;
                rem[k]--;
`endif
            end else begin
                shot_m[k][i] = 1'b1;
                rem[k]--;
                if (map_m[i]) begin
                    rev_m[k][i] = 1'b1;
                    hits[k]++;
                    ex_ac[k] = 1'b1;
                end else begin
                    ex_er[k] = 1'b1;
                end
            end
            if (hits[k] == targets)  st[k] = ST_WIN;
            else if (rem[k] == 0)    st[k] = ST_LOSE;
        end
    endtask

    task automatic fire(input int c, input int r, input int hold);
        coordColuna = 3'(c);
        coordLinha  = 3'(r);
        confirmar   = 1'b1;
        model_shot(c, r);
        @(posedge clk); #1;
        $display("[TB] shot col=%0d row=%0d: acerto=%b erro=%b repetido=%b invalido=%b fim=%b vitoria=%b",
                 c, r, acerto_o, erro_o, repetido_o, invalido_o, fim_o, vitoria_o);
        check_all("shot");
        clear_pulses();
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            check_all("hold");
        end
        confirmar = 1'b0;
        @(posedge clk); #1;
        check_all("release");
    endtask

    task automatic start_game(input logic [N-1:0] m);
        mapa    = m;
        enable  = 1'b1;
        map_m   = m;
        targets = $countones(m);
        @(posedge clk); #1;
        clear_pulses();
        for (int k = 0; k < 3; k++) begin
            st[k] = ST_LOAD; hits[k] = 0; rem[k] = budget[k]; shot_m[k] = '0; rev_m[k] = '0;
        end
        mapa = ~m;
        check_all("load_first");
        for (int e = 2; e <= N; e++) begin
            @(posedge clk); #1;
        end
        check_all("load_last");
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) st[k] = (targets == 0) ? ST_WIN : ST_PLAY;
        $display("[TB] game loaded: targets=%0d pronto=%b vitoria=%b", targets, pronto_o, vitoria_o);
        check_all("load_done");
    endtask

    task automatic stop_game(input bit with_shot);
        enable = 1'b0;
        if (with_shot) begin
            coordColuna = 3'd0;
            coordLinha  = 3'd1;
            confirmar   = 1'b1;
        end
        @(posedge clk); #1;
        model_idle();
        $display("[TB] enable dropped (shot on same edge=%0d)", with_shot);
        check_all("stop");
        confirmar = 1'b0;
        @(posedge clk); #1;
        check_all("idle");
    endtask

    initial begin
        logic [63:0] rnd;
        ships = '0;
        ships[6:0]   = 7'b1110001;
        ships[13:7]  = 7'b0100000;
        ships[34:28] = 7'b1110000;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_idle();
        check_all("reset");
        rst_n = 1'b1;

        // Opening sequence: hits, miss, repeat, invalid coordinates, held trigger
        start_game(ships);
        fire(0, 0, 1);
        fire(0, 1, 1);
        fire(1, 5, 1);
        fire(0, 0, 1);
        fire(5, 0, 1);
        fire(0, 7, 1);
        fire(2, 3, 10);
        stop_game(1'b0);

        // Sink every ship: budget 8 must win on its last shot, budget 3 loses after three
        start_game(ships);
        fire(0, 0, 1);
        fire(0, 4, 2);
        fire(0, 5, 1);
        fire(0, 6, 1);
        fire(1, 5, 3);
        fire(4, 4, 1);
        fire(4, 5, 1);
        fire(4, 6, 1);
        fire(2, 2, 1);
        stop_game(1'b0);

        // Three misses
        start_game(ships);
        fire(1, 0, 1);
        fire(2, 0, 1);
        fire(3, 3, 1);
        fire(3, 4, 1);
        stop_game(1'b0);

        // Random map and random shots (some off-grid)
        rnd = {$urandom(), $urandom()};
        start_game(rnd[N-1:0] & N'({$urandom(), $urandom()}));
        for (int s = 0; s < 30; s++) begin
            fire($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 3));
        end
        stop_game(1'b0);

        // Abort mid-play with a shot on the same edge, then an empty map wins straight away
        start_game(ships);
        fire(0, 0, 1);
        stop_game(1'b1);
        start_game('0);
        fire(0, 0, 1);
        stop_game(1'b0);

        // Reset in the middle of LOAD
        mapa   = ships;
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_idle();
        $display("[TB] reset asserted mid-load");
        check_all("rst_mid_load");
        rst_n  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
